// File: rtl/serial_paralelo.sv
// Receive-side 8:1 deserializer: comma alignment, lock and
// recovery of 9-bit {valid, data} words from an MSB-first stream.
module serial_paralelo #(
   parameter logic [7:0]  BC_PATTERN = 8'hBC,
   parameter int unsigned LOCK_BCS   = 4
) (
   input  logic       clk8f,
   input  logic       reset,
   input  logic       serial,
   output logic [8:0] paralelo,
   output logic       valid_out,
   output logic       active
);

   typedef enum logic [1:0] {
      SEARCH,
      ALIGN,
      LOCKED
   } state_t;

   localparam logic [3:0] LOCK_N = 4'(LOCK_BCS);

   state_t     state, state_n;
   // Only the 7 older bits are ever observed; the 8th lives on serial.
   logic [6:0] sr;
   logic [2:0] bit_cnt, bit_cnt_n;
   logic [3:0] bc_cnt, bc_cnt_n;
   logic [3:0] bc_inc;
   logic [8:0] par_n;
   logic       vo_n;
   logic [7:0] w;
   logic       comma;
   logic       boundary;

   assign w        = {sr, serial};
   assign comma    = (w == BC_PATTERN);
   assign boundary = (bit_cnt == 3'd7);
   assign bc_inc   = bc_cnt + 4'd1;

   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt + 3'd1;
      bc_cnt_n  = bc_cnt;
      par_n     = paralelo;
      vo_n      = 1'b0;
      unique case (state)
         SEARCH: begin
            if (comma) begin
               bit_cnt_n = 3'd0;
               bc_cnt_n  = 4'd1;
               state_n   = (LOCK_N == 4'd1) ? LOCKED : ALIGN;
            end
         end
         ALIGN: begin
            if (boundary) begin
               if (comma) begin
                  bc_cnt_n = bc_inc;
                  if (bc_inc == LOCK_N)
                     state_n = LOCKED;
               end else begin
                  bc_cnt_n = 4'd0;
                  state_n  = SEARCH;
               end
            end
         end
         LOCKED: begin
            if (boundary) begin
               par_n = comma ? {1'b0, BC_PATTERN}
                             : {1'b1, w};
               vo_n  = 1'b1;
            end
         end
         default: state_n = SEARCH;
      endcase
   end

   always_ff @(posedge clk8f) begin
      if (reset) begin
         state     <= SEARCH;
         sr        <= '0;
         bit_cnt   <= '0;
         bc_cnt    <= '0;
         paralelo  <= '0;
         valid_out <= 1'b0;
         active    <= 1'b0;
      end else begin
         state     <= state_n;
         sr        <= w[6:0];
         bit_cnt   <= bit_cnt_n;
         bc_cnt    <= bc_cnt_n;
         paralelo  <= par_n;
         valid_out <= vo_n;
         active    <= (state_n == LOCKED);
      end
   end

endmodule
